// File: rtl/grayscale_to_color.sv
// Two-stage streaming grayscale-to-RGB converter with valid/ready handshake on both sides.
// Define GRAY_FALSECOLOR_EN for the four-segment false-color map; otherwise gray is replicated to R/G/B.
module grayscale_to_color (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gray_in,
    input  logic        gray_valid,
    input  logic        gray_last,
    output logic        gray_ready,
    output logic [7:0]  R_out,
    output logic [7:0]  G_out,
    output logic [7:0]  B_out,
    output logic        rgb_valid,
    output logic        rgb_last,
    input  logic        rgb_ready,
    output logic [15:0] pixel_count
);
    logic        s1_valid_q;
    logic        s1_last_q;
    logic        s2_valid_q;
    logic        s2_last_q;
    logic [7:0]  r_q, g_q, b_q;
    logic [7:0]  r_d, g_d, b_d;
    logic [15:0] count_q;
    logic        s2_advance;
    logic        s1_load;

    assign s2_advance = !s2_valid_q || rgb_ready;
    // Ready never looks at gray_valid; it is held low while reset is asserted.
    assign gray_ready = !rst && (!s1_valid_q || s2_advance);
    assign s1_load    = gray_ready && gray_valid;

`ifdef GRAY_FALSECOLOR_EN
    logic [1:0] s1_seg_q;
    logic [7:0] s1_t_q;

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_seg_q <= gray_in[7:6];
            s1_t_q   <= {gray_in[5:0], 2'b00};
        end
    end

    always_comb begin
        r_d = 8'd0;
        g_d = 8'd0;
        b_d = 8'd0;
        unique case (s1_seg_q)
            2'b00: begin r_d = 8'd0;   g_d = s1_t_q;          b_d = 8'd255;          end
            2'b01: begin r_d = 8'd0;   g_d = 8'd255;          b_d = 8'd255 - s1_t_q; end
            2'b10: begin r_d = s1_t_q; g_d = 8'd255;          b_d = 8'd0;            end
            2'b11: begin r_d = 8'd255; g_d = 8'd255 - s1_t_q; b_d = 8'd0;            end
        endcase
    end
`else
    logic [7:0] s1_pix_q;

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_pix_q <= gray_in;
        end
    end

    always_comb begin
        r_d = s1_pix_q;
        g_d = s1_pix_q;
        b_d = s1_pix_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (gray_ready) begin
            s1_valid_q <= gray_valid;
            s1_last_q  <= gray_last;
        end
    end

    // Stage 2 only moves when downstream can take its current contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            b_q        <= 8'd0;
        end else if (s2_advance) begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'd0;
        end else if (s2_valid_q && rgb_ready) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign R_out       = r_q;
    assign G_out       = g_q;
    assign B_out       = b_q;
    assign rgb_valid   = s2_valid_q;
    assign rgb_last    = s2_last_q;
    assign pixel_count = count_q;
endmodule

// File: tb/tb_grayscale_to_color.sv
// Randomized plus directed bench for grayscale_to_color, checked against a queue-based reference model.
// Build with or without GRAY_FALSECOLOR_EN to match the RTL configuration.
module tb_grayscale_to_color;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gray_in = 8'd0;
    logic        gray_valid = 1'b0;
    logic        gray_last = 1'b0;
    logic        gray_ready;
    logic [7:0]  R_out, G_out, B_out;
    logic        rgb_valid;
    logic        rgb_last;
    logic        rgb_ready = 1'b0;
    logic [15:0] pixel_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [24:0] exp_q[$];
    logic [15:0] cnt_model = 16'd0;
    int          cyc = 0;
    int          stall_cnt = 0;
    int          xfer_n = 0;
    int          first_xfer = -1;
    int          last_xfer = -1;
    int          last_cnt = 0;
    logic        hold_prev = 1'b0;
    logic [24:0] prev_out;

    grayscale_to_color dut (
        .clk        (clk),
        .rst        (rst),
        .gray_in    (gray_in),
        .gray_valid (gray_valid),
        .gray_last  (gray_last),
        .gray_ready (gray_ready),
        .R_out      (R_out),
        .G_out      (G_out),
        .B_out      (B_out),
        .rgb_valid  (rgb_valid),
        .rgb_last   (rgb_last),
        .rgb_ready  (rgb_ready),
        .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Colormap from the segment rules, using plain integer arithmetic.
    function automatic logic [23:0] ref_map(input logic [7:0] g);
`ifdef GRAY_FALSECOLOR_EN
        int unsigned seg;
        int unsigned t;
        seg = g / 64;
        t   = (g % 64) * 4;
        case (seg)
            0:       return {8'd0, 8'(t), 8'd255};
            1:       return {8'd0, 8'd255, 8'(255 - t)};
            2:       return {8'(t), 8'd255, 8'd0};
            default: return {8'd255, 8'(255 - t), 8'd0};
        endcase
`else
        return {g, g, g};
`endif
    endfunction

    // Observer: every handshake is judged mid-cycle, before the edge that commits it.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cnt_model = 16'd0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", rgb_valid, 1'b1);
                chk("hold_data", {rgb_last, R_out, G_out, B_out}, prev_out);
            end
            chk("pixel_count", pixel_count, cnt_model);
            if (gray_valid && !gray_ready) stall_cnt++;
            if (rgb_valid && rgb_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1'b1, 1'b0);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    chk("rgb", {R_out, G_out, B_out}, e[23:0]);
                    chk("last", rgb_last, e[24]);
                end
                cnt_model = cnt_model + 16'd1;
                xfer_n++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                if (rgb_last) last_cnt++;
            end
            if (gray_valid && gray_ready) exp_q.push_back({gray_last, ref_map(gray_in)});
            chk("inflight_le2", exp_q.size() <= 2, 1'b1);
            hold_prev = rgb_valid && !rgb_ready;
            prev_out  = {rgb_last, R_out, G_out, B_out};
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; rgb_ready = 1'b1; gray_valid = 1'b0; gray_last = 1'b0;
        @(posedge clk); #1;
        chk("rst_valid", rgb_valid, 1'b0);
        chk("rst_count", pixel_count, 16'd0);
        chk("rst_rgb", {R_out, G_out, B_out}, 24'd0);
        chk("rst_last", rgb_last, 1'b0);
        chk("rst_ready", gray_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", gray_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    // Holds gray_valid until the pixel is taken; leaves gray_valid high for back-to-back use.
    task automatic push_px(input logic [7:0] v, input logic l);
        bit acc;
        acc = 1'b0;
        gray_valid = 1'b1; gray_in = v; gray_last = l;
        for (int k = 0; k < 32 && !acc; k++) begin
            @(negedge clk);
            acc = gray_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !rgb_valid;
        end
        if (!done) chk("drain_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic send_single(input string tag, input logic [7:0] v, input logic [23:0] exp);
        @(posedge clk); #1;
        gray_valid = 1'b1; gray_in = v; gray_last = 1'b0; rgb_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, gray_ready, 1'b1);
        @(posedge clk); #1;
        gray_valid = 1'b0;
        chk({tag, "_lat1"}, rgb_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, rgb_valid, 1'b1);
        chk({tag, "_rgb"}, {R_out, G_out, B_out}, exp);
    endtask

    initial begin
        do_reset();

        // Directed mapping and latency
`ifdef GRAY_FALSECOLOR_EN
        send_single("map_00", 8'h00, 24'h0000FF);
        send_single("map_FF", 8'hFF, 24'hFF0300);
        send_single("map_50", 8'h50, 24'h00FFBF);
        send_single("map_C8", 8'hC8, 24'hFFDF00);
        send_single("map_80", 8'h80, 24'h00FF00);
`else
        send_single("rep_5A", 8'h5A, 24'h5A5A5A);
        send_single("rep_00", 8'h00, 24'h000000);
        send_single("rep_FF", 8'hFF, 24'hFFFFFF);
`endif
        wait_drain();

        // Backpressure: two pixels fill the pipe, the third waits
        do_reset();
        rgb_ready = 1'b0;
        push_px(8'h10, 1'b0);
        push_px(8'h20, 1'b0);
        gray_valid = 1'b1; gray_in = 8'h30; gray_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready_low", gray_ready, 1'b0);
            chk("bp_valid", rgb_valid, 1'b1);
            chk("bp_first", {R_out, G_out, B_out}, ref_map(8'h10));
            @(posedge clk); #1;
        end
        rgb_ready = 1'b1;
        push_px(8'h30, 1'b1);
        gray_valid = 1'b0; gray_last = 1'b0;
        wait_drain();
        chk("bp_count", pixel_count, 16'd3);

        // Randomized traffic with random backpressure
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bit acc;
            @(negedge clk);
            acc = gray_valid && gray_ready;
            @(posedge clk); #1;
            if (!gray_valid || acc) begin
                gray_valid = ($urandom_range(0, 9) < 7);
                gray_in    = 8'($urandom);
                gray_last  = ($urandom_range(0, 7) == 0);
            end
            rgb_ready = ($urandom_range(0, 3) != 0);
        end
        gray_valid = 1'b0;
        rgb_ready  = 1'b1;
        wait_drain();
        chk("rand_count", pixel_count, cnt_model);

        // Full throughput: 64 back-to-back pixels, last on the 64th
        do_reset();
        stall_cnt = 0; xfer_n = 0; first_xfer = -1; last_xfer = -1; last_cnt = 0;
        for (int k = 0; k < 64; k++) push_px(8'($urandom), k == 63);
        gray_valid = 1'b0; gray_last = 1'b0;
        wait_drain();
        chk("tp_stalls", stall_cnt, 0);
        chk("tp_xfers", xfer_n, 64);
        chk("tp_consecutive", last_xfer - first_xfer, 63);
        chk("tp_last_cnt", last_cnt, 1);
        chk("tp_count", pixel_count, 16'd64);

        // Reset with two pixels in flight
        rgb_ready = 1'b0;
        push_px(8'h11, 1'b0);
        push_px(8'h22, 1'b0);
        gray_valid = 1'b0;
        @(negedge clk);
        chk("inflight_valid", rgb_valid, 1'b1);
        chk("inflight_count", pixel_count, 16'd64);
        do_reset();

        // Counter wrap after 65536 transfers
        for (int k = 0; k < 65536; k++) push_px(8'($urandom), ($urandom_range(0, 15) == 0));
        gray_valid = 1'b0; gray_last = 1'b0;
        wait_drain();
        chk("wrap_count", pixel_count, 16'h0000);
        push_px(8'h42, 1'b1);
        gray_valid = 1'b0; gray_last = 1'b0;
        wait_drain();
        chk("wrap_plus1", pixel_count, 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
